// File: rtl/slave_apb_pkg.sv
// rtl/slave_apb_pkg.sv - shared types and helpers for the APB slave bridge
//
// Contents:
//   state_t       bridge FSM states (IDLE, BUS, RESP)
//   irq_stat_ofs  byte offset of the local IRQ status register in the window
//   irq_mask_ofs  byte offset of the local IRQ mask register in the window
//   strb_merge    byte-strobe merge of new data over old data (up to 64 bits)

package slave_apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Local registers occupy the last two data words of the window.
    function automatic int irq_stat_ofs(input int win_aw, input int data_w);
        return (1 << win_aw) - 2 * (data_w / 8);
    endfunction

    function automatic int irq_mask_ofs(input int win_aw, input int data_w);
        return (1 << win_aw) - (data_w / 8);
    endfunction

    // Bytes of new_v whose strobe is set replace the matching bytes of old_v.
    function automatic logic [63:0] strb_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  strb);
        logic [63:0] r;
        r = old_v;
        for (int b = 0; b < 8; b++) begin
            if (strb[b]) begin
                r[b*8 +: 8] = new_v[b*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/slave_apb_bridge_p_irq_regs.sv
// rtl/slave_apb_bridge_p_irq_regs.sv - sticky interrupt status, mask and irq output
//
// Ports:
//   i_pclk, i_preset     clock, synchronous active-high reset
//   i_irq_src[IRQ_N]     level interrupt sources, OR-ed into status every cycle
//   i_stat_we            write-1-to-clear strobe for the status register
//   i_mask_we            write strobe for the mask register
//   i_wdata, i_wstrb     write data and byte strobes
//   o_stat, o_mask       register contents, zero-extended to DATA_W
//   o_irq                registered |(stat & mask)

module slave_apb_irq_regs
    import slave_apb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IRQ_N  = 8
) (
    input  logic                i_pclk,
    input  logic                i_preset,
    input  logic [IRQ_N-1:0]    i_irq_src,
    input  logic                i_stat_we,
    input  logic                i_mask_we,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wstrb,
    output logic [DATA_W-1:0]   o_stat,
    output logic [DATA_W-1:0]   o_mask,
    output logic                o_irq
);

    logic [IRQ_N-1:0] stat;
    logic [IRQ_N-1:0] mask;
    logic [IRQ_N-1:0] clr_v;
    logic [IRQ_N-1:0] mask_v;

    always_comb begin
        clr_v  = IRQ_N'(strb_merge(64'd0, 64'(i_wdata), 8'(i_wstrb)));
        mask_v = IRQ_N'(strb_merge(64'(mask), 64'(i_wdata), 8'(i_wstrb)));
        o_stat = '0;
        o_mask = '0;
        o_stat[IRQ_N-1:0] = stat;
        o_mask[IRQ_N-1:0] = mask;
    end

    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            stat  <= '0;
            mask  <= '0;
            o_irq <= 1'b0;
        end else begin
            // Sources are OR-ed after the clear so a still-active source wins.
            stat <= (stat & ~(i_stat_we ? clr_v : '0)) | i_irq_src;
            if (i_mask_we) begin
                mask <= mask_v;
            end
            o_irq <= |(stat & mask);
        end
    end

endmodule

// File: rtl/slave_apb_bridge_p.sv
// rtl/slave_apb_bridge_p.sv - APB4 slave bridging to a chip-select register backend
//
// Ports:
//   i_pclk, i_preset                 clock, synchronous active-high reset
//   o_irq                            registered |(irq_stat & irq_mask)
//   i_psel, i_penable, i_paddr,
//   i_pwrite, i_pwdata, i_pprot,
//   i_pstrb                          APB4 request
//   o_prdata, o_pready, o_pslverr    APB4 response (one-cycle pready)
//   o_cs, o_we, o_addr, o_wdata,
//   o_wstrb                          backend request, held until ack/timeout
//   i_rdata, i_ack                   backend response
//   i_irq_src                        level interrupt sources

module slave_apb_bridge_p
    import slave_apb_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WIN_AW      = 12,
    parameter int                TMO_CYC     = 16,
    parameter int                IRQ_N       = 8,
    parameter int                SECURE_REGS = 1
) (
    input  logic                i_pclk,
    input  logic                i_preset,
    output logic                o_irq,
    input  logic                i_psel,
    input  logic                i_penable,
    input  logic [ADDR_W-1:0]   i_paddr,
    input  logic                i_pwrite,
    input  logic [DATA_W-1:0]   i_pwdata,
    input  logic [2:0]          i_pprot,
    input  logic [DATA_W/8-1:0] i_pstrb,
    output logic [DATA_W-1:0]   o_prdata,
    output logic                o_pready,
    output logic                o_pslverr,
    output logic                o_cs,
    output logic                o_we,
    output logic [WIN_AW-1:0]   o_addr,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W/8-1:0] o_wstrb,
    input  logic [DATA_W-1:0]   i_rdata,
    input  logic                i_ack,
    input  logic [IRQ_N-1:0]    i_irq_src
);

    localparam int SW = DATA_W / 8;
    localparam int AL = $clog2(SW);
    localparam int CW = $clog2(TMO_CYC + 1);
    localparam logic [WIN_AW-1:0] STAT_OFS = WIN_AW'(irq_stat_ofs(WIN_AW, DATA_W));
    localparam logic [WIN_AW-1:0] MASK_OFS = WIN_AW'(irq_mask_ofs(WIN_AW, DATA_W));

    state_t            state_q, state_d;
    logic              cs_d, we_d, pready_d, pslverr_d;
    logic [WIN_AW-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, prdata_d;
    logic [SW-1:0]     wstrb_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic              access, in_win, misaligned, hit_stat, hit_mask, prot_err;
    logic              stat_we, mask_we;
    logic [DATA_W-1:0] stat_rd, mask_rd;
    logic              unused_prot;

    assign unused_prot = ^{i_pprot[2], i_pprot[0]};

    always_comb begin
        access     = i_psel & i_penable;
        in_win     = (i_paddr[ADDR_W-1:WIN_AW] == BASE_ADDR[ADDR_W-1:WIN_AW]);
        misaligned = |i_paddr[AL-1:0];
        hit_stat   = (i_paddr[WIN_AW-1:0] == STAT_OFS);
        hit_mask   = (i_paddr[WIN_AW-1:0] == MASK_OFS);
        prot_err   = (SECURE_REGS != 0) && i_pprot[1];
    end

    always_comb begin
        state_d   = state_q;
        cs_d      = o_cs;
        we_d      = o_we;
        addr_d    = o_addr;
        wdata_d   = o_wdata;
        wstrb_d   = o_wstrb;
        cnt_d     = cnt_q;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        stat_we   = 1'b0;
        mask_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (!in_win || misaligned) begin
                        state_d   = RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                    end else if (hit_stat || hit_mask) begin
                        state_d  = RESP;
                        pready_d = 1'b1;
                        if (prot_err) begin
                            pslverr_d = 1'b1;
                        end else if (i_pwrite) begin
                            stat_we = hit_stat;
                            mask_we = hit_mask;
                        end else begin
                            prdata_d = hit_stat ? stat_rd : mask_rd;
                        end
                    end else begin
                        state_d = BUS;
                        cs_d    = 1'b1;
                        we_d    = i_pwrite;
                        addr_d  = i_paddr[WIN_AW-1:0];
                        wdata_d = i_pwrite ? i_pwdata : '0;
                        wstrb_d = i_pwrite ? i_pstrb : '0;
                        cnt_d   = '0;
                    end
                end
            end
            BUS: begin
                // Ack has priority over timeout in the final allowed cycle.
                if (i_ack || (cnt_q == CW'(TMO_CYC - 1))) begin
                    state_d   = RESP;
                    pready_d  = 1'b1;
                    pslverr_d = !i_ack;
                    prdata_d  = (i_ack && !o_we) ? i_rdata : '0;
                    cs_d      = 1'b0;
                    we_d      = 1'b0;
                    addr_d    = '0;
                    wdata_d   = '0;
                    wstrb_d   = '0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_pclk) begin
        if (i_preset) begin
            state_q   <= IDLE;
            o_cs      <= 1'b0;
            o_we      <= 1'b0;
            o_addr    <= '0;
            o_wdata   <= '0;
            o_wstrb   <= '0;
            o_prdata  <= '0;
            o_pready  <= 1'b0;
            o_pslverr <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            o_cs      <= cs_d;
            o_we      <= we_d;
            o_addr    <= addr_d;
            o_wdata   <= wdata_d;
            o_wstrb   <= wstrb_d;
            o_prdata  <= prdata_d;
            o_pready  <= pready_d;
            o_pslverr <= pslverr_d;
            cnt_q     <= cnt_d;
        end
    end

    slave_apb_irq_regs #(
        .DATA_W (DATA_W),
        .IRQ_N  (IRQ_N)
    ) u_irq_regs (
        .i_pclk    (i_pclk),
        .i_preset  (i_preset),
        .i_irq_src (i_irq_src),
        .i_stat_we (stat_we),
        .i_mask_we (mask_we),
        .i_wdata   (i_pwdata),
        .i_wstrb   (i_pstrb),
        .o_stat    (stat_rd),
        .o_mask    (mask_rd),
        .o_irq     (o_irq)
    );

endmodule

// File: tb/tb_slave_apb_bridge_p.sv
// tb/tb_slave_apb_bridge_p.sv - self-checking bench for slave_apb_bridge_p

module tb_slave_apb_bridge_p;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [11:0] STAT = 12'hFF8;
    localparam logic [11:0] MASK = 12'hFFC;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          ack_at;
        logic [31:0] rdata;
        int          exp_lat;
        logic [31:0] exp_prdata;
        logic        exp_err;
        int          exp_cs;
        logic [3:0]  exp_wstrb;
    } vec_t;

    logic        clk = 1'b0;
    logic        preset, psel, penable, pwrite, ack, irq, pready, pslverr;
    logic        cs, we;
    logic [31:0] paddr, pwdata, prdata, rdata, wdata;
    logic [2:0]  pprot;
    logic [3:0]  pstrb, wstrb;
    logic [11:0] addr;
    logic [7:0]  irq_src;

    int          checks = 0;
    int          errors = 0;
    int          ack_at = 0;
    int          cs_cnt = 0;
    logic [31:0] be_rdata = '0;
    logic [11:0] cap_addr;
    logic        cap_we;
    logic [3:0]  cap_wstrb;
    logic [31:0] cap_wdata;
    vec_t        sb[$];
    vec_t        vecs[9];

    always #5 clk = ~clk;

    slave_apb_bridge_p #(
        .DATA_W(32), .ADDR_W(32), .BASE_ADDR(BASE), .WIN_AW(12),
        .TMO_CYC(16), .IRQ_N(8), .SECURE_REGS(1)
    ) dut (
        .i_pclk(clk), .i_preset(preset), .o_irq(irq),
        .i_psel(psel), .i_penable(penable), .i_paddr(paddr), .i_pwrite(pwrite),
        .i_pwdata(pwdata), .i_pprot(pprot), .i_pstrb(pstrb),
        .o_prdata(prdata), .o_pready(pready), .o_pslverr(pslverr),
        .o_cs(cs), .o_we(we), .o_addr(addr), .o_wdata(wdata), .o_wstrb(wstrb),
        .i_rdata(rdata), .i_ack(ack), .i_irq_src(irq_src)
    );

    // Backend model: acks in the ack_at-th cycle of o_cs (0 = never).
    initial begin
        ack = 1'b0;
        rdata = '0;
        forever begin
            @(negedge clk);
            if (cs) begin
                cs_cnt++;
                cap_addr  = addr;
                cap_we    = we;
                cap_wstrb = wstrb;
                cap_wdata = wdata;
                ack   = (ack_at != 0) && (cs_cnt == ack_at);
                rdata = be_rdata;
            end else begin
                ack = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t loc(input logic wr, input logic [11:0] ofs, input logic [31:0] d,
                                 input logic [3:0] s, input logic [2:0] p,
                                 input logic [31:0] exp_prd, input logic exp_err);
        vec_t v;
        v.wr = wr; v.addr = BASE + 32'(ofs); v.wdata = d; v.strb = s; v.prot = p;
        v.ack_at = 0; v.rdata = '0; v.exp_lat = 1; v.exp_prdata = exp_prd;
        v.exp_err = exp_err; v.exp_cs = 0; v.exp_wstrb = '0;
        return v;
    endfunction

    task automatic run(input vec_t v);
        vec_t e;
        int   n;
        logic got;
        ack_at   = v.ack_at;
        be_rdata = v.rdata;
        cs_cnt   = 0;
        sb.push_back(v);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr;
        pwdata = v.wdata; pstrb = v.strb; pprot = v.prot;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (pready) got = 1'b1;
        end
        e = sb.pop_front();
        chk("pready_seen", 64'(got), 64'd1);
        chk("latency", 64'(n), 64'(e.exp_lat));
        chk("prdata", 64'(prdata), 64'(e.exp_prdata));
        chk("pslverr", 64'(pslverr), 64'(e.exp_err));
        chk("cs_cycles", 64'(cs_cnt), 64'(e.exp_cs));
        if (e.exp_cs > 0) begin
            chk("be_addr", 64'(cap_addr), 64'(e.addr[11:0]));
            chk("be_we", 64'(cap_we), 64'(e.wr));
            chk("be_wstrb", 64'(cap_wstrb), 64'(e.exp_wstrb));
            if (e.wr) chk("be_wdata", 64'(cap_wdata), 64'(e.wdata));
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        ack_at = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic seen;
        //          wr    addr                 wdata         strb     prot    ack rdata         lat prdata        err  cs  wstrb
        vecs[0] = '{1'b0, BASE + 32'h010,      32'h0,        4'b0000, 3'b000, 1,  32'hA5A5_0001, 2,  32'hA5A5_0001, 1'b0, 1,  4'b0000};
        vecs[1] = '{1'b1, BASE + 32'h020,      32'hDEAD_BEEF, 4'b0101, 3'b000, 3,  32'h0,        4,  32'h0,        1'b0, 3,  4'b0101};
        vecs[2] = '{1'b0, BASE + 32'h030,      32'h0,        4'b0000, 3'b000, 0,  32'h1234_5678, 17, 32'h0,        1'b1, 16, 4'b0000};
        vecs[3] = '{1'b0, BASE + 32'h1002,     32'h0,        4'b0000, 3'b000, 1,  32'h1,        1,  32'h0,        1'b1, 0,  4'b0000};
        vecs[4] = '{1'b1, BASE + 32'h003,      32'h5,        4'b1111, 3'b000, 1,  32'h1,        1,  32'h0,        1'b1, 0,  4'b0000};
        vecs[5] = '{1'b0, BASE - 32'h100,      32'h0,        4'b0000, 3'b000, 1,  32'h1,        1,  32'h0,        1'b1, 0,  4'b0000};
        vecs[6] = '{1'b0, BASE + 32'hFF4,      32'h0,        4'b0000, 3'b000, 2,  32'h0BAD_F00D, 3,  32'h0BAD_F00D, 1'b0, 2,  4'b0000};
        vecs[7] = '{1'b0, BASE + 32'h100,      32'h0,        4'b0000, 3'b000, 16, 32'hCAFE_0016, 17, 32'hCAFE_0016, 1'b0, 16, 4'b0000};
        vecs[8] = '{1'b1, BASE + 32'hFF0,      32'h1122_3344, 4'b1111, 3'b010, 1,  32'h0,        2,  32'h0,        1'b0, 1,  4'b1111};

        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pprot = '0; pstrb = '0; irq_src = '0;
        repeat (3) @(posedge clk);
        #1;
        preset = 1'b0;
        chk("rst_cs", 64'(cs), 64'd0);
        chk("rst_pready", 64'(pready), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        chk("rst_prdata", 64'(prdata), 64'd0);

        for (int i = 0; i < 9; i++) run(vecs[i]);

        // Interrupt block: sticky status, mask, W1C with set priority, protection.
        irq_src = 8'h05;
        run(loc(1'b1, MASK, 32'h04, 4'b1111, 3'b000, 32'h0, 1'b0));
        @(posedge clk); #1;
        chk("irq_set", 64'(irq), 64'd1);
        run(loc(1'b0, STAT, 32'h0, 4'b0000, 3'b000, 32'h05, 1'b0));
        run(loc(1'b1, STAT, 32'h04, 4'b1111, 3'b000, 32'h0, 1'b0));
        run(loc(1'b0, STAT, 32'h0, 4'b0000, 3'b000, 32'h05, 1'b0));
        irq_src = 8'h00;
        run(loc(1'b1, STAT, 32'h04, 4'b1111, 3'b000, 32'h0, 1'b0));
        @(posedge clk); #1;
        chk("irq_clr", 64'(irq), 64'd0);
        run(loc(1'b0, STAT, 32'h0, 4'b0000, 3'b000, 32'h01, 1'b0));
        run(loc(1'b1, STAT, 32'h01, 4'b0000, 3'b000, 32'h0, 1'b0));
        run(loc(1'b0, STAT, 32'h0, 4'b0000, 3'b000, 32'h01, 1'b0));
        run(loc(1'b1, MASK, 32'hFF, 4'b1111, 3'b010, 32'h0, 1'b1));
        run(loc(1'b0, MASK, 32'h0, 4'b0000, 3'b000, 32'h04, 1'b0));
        run(loc(1'b0, MASK, 32'h0, 4'b0000, 3'b010, 32'h0, 1'b1));
        run(loc(1'b1, MASK, 32'hFFFF_FFFF, 4'b1111, 3'b000, 32'h0, 1'b0));
        run(loc(1'b0, MASK, 32'h0, 4'b0000, 3'b000, 32'hFF, 1'b0));
        @(posedge clk); #1;
        chk("irq_mask_all", 64'(irq), 64'd1);

        // Reset while the backend access is outstanding.
        ack_at = 0;
        cs_cnt = 0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = BASE + 32'h040; pprot = '0;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("midrst_pre_cs", 64'(cs), 64'd1);
        preset = 1'b1; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        preset = 1'b0;
        chk("midrst_cs", 64'(cs), 64'd0);
        chk("midrst_pready", 64'(pready), 64'd0);
        chk("midrst_irq", 64'(irq), 64'd0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (pready || cs) seen = 1'b1;
        end
        chk("midrst_quiet", 64'(seen), 64'd0);
        run(loc(1'b0, STAT, 32'h0, 4'b0000, 3'b000, 32'h0, 1'b0));
        run(loc(1'b0, MASK, 32'h0, 4'b0000, 3'b000, 32'h0, 1'b0));
        run(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
